// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed hex display driver.
// Scans NUM_DIGITS nibbles onto a shared SEG/DP bus with one-hot anode strobes.
// Data is double buffered: LOAD fills a shadow copy, and the shadow moves into
// the display register only at a slot boundary, so a lit digit never changes
// while it is on. A dead gap with all anodes off opens every slot to stop
// ghosting when the anode switches. Every output comes straight from a flop.
module seg7_scan #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int GAP_CYCLES  = 1000,
   parameter int LZ_SUPPRESS = 0,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    en_i,
   input  logic                    load_i,
   input  logic [4*NUM_DIGITS-1:0] data_i,
   input  logic [NUM_DIGITS-1:0]   dp_in_i,
   input  logic [NUM_DIGITS-1:0]   blank_i,
   output logic [6:0]              seg_o,
   output logic [NUM_DIGITS-1:0]   an_o,
   output logic                    dp_o
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic OFF = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   typedef enum logic {ST_GAP, ST_ON} state_t;

   // With no gap configured, the GAP state is never entered, so the idle,
   // reset and slot-wrap target becomes ON.
   localparam state_t ST_IDLE = (GAP_CYCLES == 0) ? ST_ON : ST_GAP;

   logic [4*NUM_DIGITS-1:0] shadowData_q;
   logic [NUM_DIGITS-1:0]   shadowDp_q;
   logic [NUM_DIGITS-1:0]   shadowBlank_q;
   logic [4*NUM_DIGITS-1:0] dispData_q;
   logic [NUM_DIGITS-1:0]   dispDp_q;
   logic [NUM_DIGITS-1:0]   dispBlank_q;
   logic [CW-1:0]           cnt_q;
   logic [IW-1:0]           idx_q;
   state_t                  state_q;
   state_t                  state_d;
   logic [6:0]              seg_q;
   logic [6:0]              seg_d;
   logic [NUM_DIGITS-1:0]   an_q;
   logic [NUM_DIGITS-1:0]   an_d;
   logic                    dp_q;
   logic                    dp_d;

   logic                    slotStart;
   logic [4*NUM_DIGITS-1:0] effData;
   logic [NUM_DIGITS-1:0]   effDp;
   logic [NUM_DIGITS-1:0]   effBlank;
   logic [NUM_DIGITS-1:0]   suppressed;
   logic                    zeroRun;
   logic [NUM_DIGITS-1:0]   oneHot;
   logic [3:0]              curNibble;
   logic                    curDp;
   logic                    curBlank;
   logic                    curSupp;
   logic [NUM_DIGITS-1:0]   anLow;
   logic [6:0]              segLow;
   logic                    dpLow;

   // Active-low segment patterns {g,f,e,d,c,b,a} for each hex digit.
   function automatic logic [6:0] decodeHex(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   assign slotStart = (cnt_q == '0);

   // Shadow buffer: capture the host's data whenever LOAD is high.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shadowData_q  <= '0;
         shadowDp_q    <= '0;
         shadowBlank_q <= '0;
      end else if (load_i) begin
         shadowData_q  <= data_i;
         shadowDp_q    <= dp_in_i;
         shadowBlank_q <= blank_i;
      end
   end

   // Display register: take the shadow on the first cycle of each slot. A LOAD
   // in that same cycle lands in the shadow and waits for the next boundary.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dispData_q  <= '0;
         dispDp_q    <= '0;
         dispBlank_q <= '0;
      end else if (en_i && slotStart) begin
         dispData_q  <= shadowData_q;
         dispDp_q    <= shadowDp_q;
         dispBlank_q <= shadowBlank_q;
      end
   end

   // Slot counter and digit index: the index advances on each counter wrap.
   // Both are parked at zero while the display is disabled.
   always_ff @(posedge clk_i) begin
      if (rst_i || !en_i) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_q <= '0;
         idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: leave GAP on the last gap cycle, and return at the wrap.
   always_comb begin
      state_d = state_q;
      if (!en_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_GAP: if (cnt_q == GAP_LAST) state_d = ST_ON;
            ST_ON:  if (cnt_q == CNT_LAST) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Display contents seen by the decoder. On a slot's first cycle the copy is
   // still in flight, so the shadow is used directly. This only matters when
   // there is no gap and that first cycle is already lit.
   always_comb begin
      effData  = slotStart ? shadowData_q  : dispData_q;
      effDp    = slotStart ? shadowDp_q    : dispDp_q;
      effBlank = slotStart ? shadowBlank_q : dispBlank_q;
   end

   // Leading-zero suppression: walk from the top digit down while all nibbles
   // seen so far are zero. Digit 0 always stays visible.
   always_comb begin
      suppressed = '0;
      zeroRun    = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zeroRun = zeroRun && (effData[4*i +: 4] == 4'h0);
         suppressed[i] = (LZ_SUPPRESS != 0) && (i > 0) && zeroRun;
      end
   end

   // Select the current digit's nibble and attributes, and build its strobe.
   always_comb begin
      oneHot    = '0;
      curNibble = 4'h0;
      curDp     = 1'b0;
      curBlank  = 1'b0;
      curSupp   = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (IW'(i) == idx_q) begin
            oneHot[i] = 1'b1;
            curNibble = effData[4*i +: 4];
            curDp     = effDp[i];
            curBlank  = effBlank[i];
            curSupp   = suppressed[i];
         end
      end
   end

   // FSM outputs: form active-low values, then flip them for active-high boards.
   // A suppressed digit with its point set keeps its anode so the DP can show.
   always_comb begin
      anLow  = '1;
      segLow = '1;
      dpLow  = 1'b1;
      if (en_i && (state_q == ST_ON) && !curBlank) begin
         if (curSupp) begin
            if (curDp) begin
               anLow = ~oneHot;
               dpLow = 1'b0;
            end
         end else begin
            anLow  = ~oneHot;
            segLow = decodeHex(curNibble);
            dpLow  = ~curDp;
         end
      end
      if (ACTIVE_LOW != 0) begin
         an_d  = anLow;
         seg_d = segLow;
         dp_d  = dpLow;
      end else begin
         an_d  = ~anLow;
         seg_d = ~segLow;
         dp_d  = ~dpLow;
      end
   end

   // Output registers: the pins follow the internal state one cycle later.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         an_q  <= {NUM_DIGITS{OFF}};
         seg_q <= {7{OFF}};
         dp_q  <= OFF;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign an_o  = an_q;
   assign seg_o = seg_q;
   assign dp_o  = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed test of seg7_scan with 4 digits, 8-cycle slots and
// a 2-cycle gap. Two instances share every input: one with leading-zero
// suppression off and one with it on.
module tb_seg7_scan;

   logic        clk;
   logic        rst;
   logic        en;
   logic        load;
   logic [15:0] data;
   logic [3:0]  dpIn;
   logic [3:0]  blank;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        dp;
   logic [6:0]  segLz;
   logic [3:0]  anLz;
   logic        dpLz;

   int compared = 0;
   int mismatched = 0;

   seg7_scan #(
      .NUM_DIGITS(4), .REFRESH_DIV(8), .GAP_CYCLES(2), .LZ_SUPPRESS(0), .ACTIVE_LOW(1)
   ) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .load_i(load), .data_i(data),
      .dp_in_i(dpIn), .blank_i(blank), .seg_o(seg), .an_o(an), .dp_o(dp)
   );

   seg7_scan #(
      .NUM_DIGITS(4), .REFRESH_DIV(8), .GAP_CYCLES(2), .LZ_SUPPRESS(1), .ACTIVE_LOW(1)
   ) dutLz (
      .clk_i(clk), .rst_i(rst), .en_i(en), .load_i(load), .data_i(data),
      .dp_in_i(dpIn), .blank_i(blank), .seg_o(segLz), .an_o(anLz), .dp_o(dpLz)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive all inputs, then let the given number of rising edges pass and stop
   // 1 unit after the last one, away from the edge.
   task automatic applyStimulus(input logic r, input logic e, input logic l,
                                input logic [15:0] d, input logic [3:0] p,
                                input logic [3:0] b, input int cycles);
      rst = r; en = e; load = l; data = d; dpIn = p; blank = b;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   // Compare the suppression-off instance against expected pin values.
   task automatic checkOutput(input string tag, input logic [3:0] expAn,
                              input logic [6:0] expSeg, input logic expDp);
      compared++;
      assert ({an, seg, dp} === {expAn, expSeg, expDp})
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                tag, an, seg, dp, expAn, expSeg, expDp);
      end
   endtask

   // Compare the suppression-on instance against expected pin values.
   task automatic checkLz(input string tag, input logic [3:0] expAn,
                          input logic [6:0] expSeg, input logic expDp);
      compared++;
      assert ({anLz, segLz, dpLz} === {expAn, expSeg, expDp})
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                tag, anLz, segLz, dpLz, expAn, expSeg, expDp);
      end
   endtask

   // Directed sequence. Edge Fk is the k-th edge after reset release. At Fk the
   // outputs show counter (k-1)%8 of slot (k-1)/8, and the digit is slot%4.
   initial begin
      applyStimulus(1, 1, 0, 16'h0000, 4'b0000, 4'b0000, 3);
      checkOutput("reset", 4'b1111, 7'b1111111, 1'b1);
      checkLz("resetLz", 4'b1111, 7'b1111111, 1'b1);

      // Load 1234 on the first free edge. Slot 0 still shows the cleared display.
      applyStimulus(0, 1, 1, 16'h1234, 4'b0000, 4'b0000, 1);
      checkOutput("gapAfterReset", 4'b1111, 7'b1111111, 1'b1);
      applyStimulus(0, 1, 0, 16'h1234, 4'b0000, 4'b0000, 2);
      checkOutput("slot0Cleared", 4'b1110, 7'b1000000, 1'b1);
      applyStimulus(0, 1, 0, 16'h1234, 4'b0000, 4'b0000, 5);
      checkOutput("slot0LastCycle", 4'b1110, 7'b1000000, 1'b1);
      applyStimulus(0, 1, 0, 16'h1234, 4'b0000, 4'b0000, 1);
      checkOutput("slot1Gap", 4'b1111, 7'b1111111, 1'b1);
      applyStimulus(0, 1, 0, 16'h1234, 4'b0000, 4'b0000, 2);
      checkOutput("digit1Is3", 4'b1101, 7'b0110000, 1'b1);
      applyStimulus(0, 1, 0, 16'h1234, 4'b0000, 4'b0000, 8);
      checkOutput("digit2Is2", 4'b1011, 7'b0100100, 1'b1);
      applyStimulus(0, 1, 0, 16'h1234, 4'b0000, 4'b0000, 8);
      checkOutput("digit3Is1", 4'b0111, 7'b1111001, 1'b1);
      applyStimulus(0, 1, 0, 16'h1234, 4'b0000, 4'b0000, 8);
      checkOutput("digit0Is4", 4'b1110, 7'b0011001, 1'b1);
      applyStimulus(0, 1, 0, 16'h1234, 4'b0000, 4'b0000, 8);
      checkOutput("digit1Again", 4'b1101, 7'b0110000, 1'b1);

      // Load ABCD in the middle of digit 1's slot. That slot keeps showing 3.
      applyStimulus(0, 1, 1, 16'hABCD, 4'b0000, 4'b0000, 1);
      checkOutput("midSlotHold", 4'b1101, 7'b0110000, 1'b1);
      applyStimulus(0, 1, 0, 16'hABCD, 4'b0000, 4'b0000, 4);
      checkOutput("slotEndHold", 4'b1101, 7'b0110000, 1'b1);
      applyStimulus(0, 1, 0, 16'hABCD, 4'b0000, 4'b0000, 3);
      checkOutput("newDigit2b", 4'b1011, 7'b0000011, 1'b1);
      applyStimulus(0, 1, 0, 16'hABCD, 4'b0000, 4'b0000, 8);
      checkOutput("newDigit3A", 4'b0111, 7'b0001000, 1'b1);
      applyStimulus(0, 1, 0, 16'hABCD, 4'b0000, 4'b0000, 8);
      checkOutput("newDigit0d", 4'b1110, 7'b0100001, 1'b1);
      applyStimulus(0, 1, 0, 16'hABCD, 4'b0000, 4'b0000, 8);
      checkOutput("newDigit1C", 4'b1101, 7'b1000110, 1'b1);
      applyStimulus(0, 1, 0, 16'hABCD, 4'b0000, 4'b0000, 5);

      // Load 0050 with DP on digit 3 in a slot's first cycle (F81). Copy uses the old shadow.
      applyStimulus(0, 1, 1, 16'h0050, 4'b1000, 4'b0000, 1);
      applyStimulus(0, 1, 0, 16'h0050, 4'b1000, 4'b0000, 2);
      checkOutput("boundaryLoadDeferred", 4'b1011, 7'b0000011, 1'b1);
      applyStimulus(0, 1, 0, 16'h0050, 4'b1000, 4'b0000, 8);
      checkOutput("noLzDigit3", 4'b0111, 7'b1000000, 1'b0);
      checkLz("lzDigit3DpOnly", 4'b0111, 7'b1111111, 1'b0);
      applyStimulus(0, 1, 0, 16'h0050, 4'b1000, 4'b0000, 8);
      checkOutput("noLzDigit0", 4'b1110, 7'b1000000, 1'b1);
      checkLz("lzDigit0Kept", 4'b1110, 7'b1000000, 1'b1);
      applyStimulus(0, 1, 0, 16'h0050, 4'b1000, 4'b0000, 8);
      checkOutput("noLzDigit1", 4'b1101, 7'b0010010, 1'b1);
      checkLz("lzDigit1Is5", 4'b1101, 7'b0010010, 1'b1);
      applyStimulus(0, 1, 0, 16'h0050, 4'b1000, 4'b0000, 8);
      checkOutput("noLzDigit2", 4'b1011, 7'b1000000, 1'b1);
      checkLz("lzDigit2Blank", 4'b1111, 7'b1111111, 1'b1);

      // Load 8888 with digit 2 blanked. The copy happens at F121, in digit 3's slot.
      applyStimulus(0, 1, 1, 16'h8888, 4'b0000, 4'b0100, 1);
      applyStimulus(0, 1, 0, 16'h8888, 4'b0000, 4'b0100, 7);
      checkOutput("blankDigit3", 4'b0111, 7'b0000000, 1'b1);
      applyStimulus(0, 1, 0, 16'h8888, 4'b0000, 4'b0100, 8);
      checkOutput("blankDigit0", 4'b1110, 7'b0000000, 1'b1);
      applyStimulus(0, 1, 0, 16'h8888, 4'b0000, 4'b0100, 8);
      checkOutput("blankDigit1", 4'b1101, 7'b0000000, 1'b1);
      applyStimulus(0, 1, 0, 16'h8888, 4'b0000, 4'b0100, 8);
      checkOutput("blankDigit2Early", 4'b1111, 7'b1111111, 1'b1);
      applyStimulus(0, 1, 0, 16'h8888, 4'b0000, 4'b0100, 5);
      checkOutput("blankDigit2Late", 4'b1111, 7'b1111111, 1'b1);
      applyStimulus(0, 1, 0, 16'h8888, 4'b0000, 4'b0100, 3);
      checkOutput("blankDigit3Again", 4'b0111, 7'b0000000, 1'b1);

      // Drop EN for 5 edges in the middle of a slot, then restart from digit 0.
      applyStimulus(0, 0, 0, 16'h8888, 4'b0000, 4'b0100, 1);
      checkOutput("enOffNext", 4'b1111, 7'b1111111, 1'b1);
      applyStimulus(0, 0, 0, 16'h8888, 4'b0000, 4'b0100, 4);
      checkOutput("enOffHeld", 4'b1111, 7'b1111111, 1'b1);
      applyStimulus(0, 1, 0, 16'h8888, 4'b0000, 4'b0100, 1);
      checkOutput("enRiseGap0", 4'b1111, 7'b1111111, 1'b1);
      applyStimulus(0, 1, 0, 16'h8888, 4'b0000, 4'b0100, 1);
      checkOutput("enRiseGap1", 4'b1111, 7'b1111111, 1'b1);
      applyStimulus(0, 1, 0, 16'h8888, 4'b0000, 4'b0100, 1);
      checkOutput("enRiseDigit0", 4'b1110, 7'b0000000, 1'b1);

      // Reload 1234 unblanked, wait until digit 2 is lit, then pulse reset.
      applyStimulus(0, 1, 1, 16'h1234, 4'b0000, 4'b0000, 1);
      applyStimulus(0, 1, 0, 16'h1234, 4'b0000, 4'b0000, 15);
      checkOutput("preResetDigit2", 4'b1011, 7'b0100100, 1'b1);
      applyStimulus(1, 1, 0, 16'h1234, 4'b0000, 4'b0000, 1);
      checkOutput("resetPulseOff", 4'b1111, 7'b1111111, 1'b1);
      checkLz("resetPulseOffLz", 4'b1111, 7'b1111111, 1'b1);
      applyStimulus(0, 1, 0, 16'h1234, 4'b0000, 4'b0000, 3);
      checkOutput("postResetDigit0", 4'b1110, 7'b1000000, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
